// File: rtl/wbq_pkg.sv
// Shared types and constants for the write-back queue.
// Entry layout is fixed at the register-file widths (5-bit address, 32-bit data).
package wbq_pkg;

  localparam int WBQ_AW       = 5;
  localparam int WBQ_DW       = 32;
  localparam int WBQ_REG_ZERO = 0;

  typedef struct packed {
    logic [WBQ_AW-1:0] addr;
    logic [WBQ_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-first lookup of a register address over the pending queue entries
// and the register-file output register, so decode can pick up values that
// have not reached the register file yet.
module wbq_fwd_match
  import wbq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = WBQ_AW,
  parameter int DW    = WBQ_DW,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     rptr,
  input  logic [CW-1:0]     count,
  input  logic              out_valid,
  input  logic [AW-1:0]     out_addr,
  input  logic [DW-1:0]     out_data,
  input  logic [AW-1:0]     lookup_addr,
  output logic              hit,
  output logic [DW-1:0]     data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides earlier ones;
  // the output register is older than every queued entry, so it is seeded first.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (out_valid && out_addr == lookup_addr) begin
      hit  = 1'b1;
      data = out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < count && entries[idx].addr == lookup_addr) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
    if (lookup_addr == AW'(WBQ_REG_ZERO)) begin
      hit  = 1'b0;
      data = '0;
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: accepts up to two retiring results per cycle (slot 0 older),
// drops writes to register 0, and drains one entry per cycle onto the single
// register-file write port through a registered output stage.
// Optional feature macro WBQ_FWD_EN adds the fwd_addr/fwd_hit/fwd_data lookup port.
module wb_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = WBQ_DW,
  parameter int AW    = WBQ_AW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in0_valid,
  input  logic [AW-1:0]              in0_addr,
  input  logic [DW-1:0]              in0_data,
  input  logic                       in1_valid,
  input  logic [AW-1:0]              in1_addr,
  input  logic [DW-1:0]              in1_data,
  output logic                       in_ready,
  output logic                       rf_write,
  output logic [AW-1:0]              rf_wr,
  output logic [DW-1:0]              rf_wd,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_ovf
`ifdef WBQ_FWD_EN
  ,
  input  logic [AW-1:0]              fwd_addr,
  output logic                       fwd_hit,
  output logic [DW-1:0]              fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_write_q, rf_write_d;
  logic [AW-1:0] rf_wr_q, rf_wr_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;
  logic          err_ovf_q, err_ovf_d;

  logic push0, push1, pop;

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign push0    = in_ready && in0_valid && (in0_addr != AW'(WBQ_REG_ZERO));
  assign push1    = in_ready && in1_valid && (in1_addr != AW'(WBQ_REG_ZERO));
  assign pop      = (count_q != '0);

  assign rf_write = rf_write_q;
  assign rf_wr    = rf_wr_q;
  assign rf_wd    = rf_wd_q;
  assign count    = count_q;
  assign err_ovf  = err_ovf_q;

  // Next-state: enqueue accepted slots in order, move the head into the output register.
  always_comb begin
    mem_d      = mem_q;
    rf_wr_d    = rf_wr_q;
    rf_wd_d    = rf_wd_q;
    rptr_d     = rptr_q;
    rf_write_d = pop;
    if (push0) begin
      mem_d[wptr_q] = '{addr: in0_addr, data: in0_data};
    end
    if (push1) begin
      mem_d[wptr_q + PW'(push0)] = '{addr: in1_addr, data: in1_data};
    end
    wptr_d = wptr_q + PW'(push0) + PW'(push1);
    if (pop) begin
      rf_wr_d = mem_q[rptr_q].addr;
      rf_wd_d = mem_q[rptr_q].data;
      rptr_d  = rptr_q + PW'(1);
    end
    count_d   = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    err_ovf_d = err_ovf_q | ((in0_valid | in1_valid) & ~in_ready);
  end

  // Control state and output register; reset drops everything pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rf_write_q <= 1'b0;
      rf_wr_q    <= '0;
      rf_wd_q    <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rf_write_q <= rf_write_d;
      rf_wr_q    <= rf_wr_d;
      rf_wd_q    <= rf_wd_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Entry storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef WBQ_FWD_EN
  wbq_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd_match (
    .entries     (mem_q),
    .rptr        (rptr_q),
    .count       (count_q),
    .out_valid   (rf_write_q),
    .out_addr    (rf_wr_q),
    .out_data    (rf_wd_q),
    .lookup_addr (fwd_addr),
    .hit         (fwd_hit),
    .data        (fwd_data)
  );
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: a model tracks occupancy and error state,
// accepted results go into a scoreboard queue and are matched against each
// register-file write the DUT makes.
module tb_wb_queue;
  import wbq_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in0_valid, in1_valid;
  logic [AW-1:0] in0_addr, in1_addr;
  logic [DW-1:0] in0_data, in1_data;
  logic          in_ready;
  logic          rf_write;
  logic [AW-1:0] rf_wr;
  logic [DW-1:0] rf_wd;
  logic [CW-1:0] count;
  logic          err_ovf;
  logic [AW-1:0] tbFwdAddr;
`ifdef WBQ_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  wb_entry_t sbq[$];
  int        mCount;
  logic      mOvf;
  logic      mLastValid;
  wb_entry_t mLast;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_addr  (in0_addr),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_addr  (in1_addr),
    .in1_data  (in1_data),
    .in_ready  (in_ready),
    .rf_write  (rf_write),
    .rf_wr     (rf_wr),
    .rf_wd     (rf_wd),
    .count     (count),
    .err_ovf   (err_ovf)
`ifdef WBQ_FWD_EN
    ,
    .fwd_addr  (tbFwdAddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef WBQ_FWD_EN
  // Expected lookup result {hit, data}: youngest queued match, else the output register.
  function automatic logic [DW:0] fwdModel(input logic [AW-1:0] a);
    logic [DW:0] r;
    r = '0;
    if (a != '0) begin
      if (mLastValid && mLast.addr == a) r = {1'b1, mLast.data};
      foreach (sbq[i]) begin
        if (sbq[i].addr == a) r = {1'b1, sbq[i].data};
      end
    end
    return r;
  endfunction
`endif

  // Compare DUT state sampled at the falling edge against the model.
  task automatic checkState(input logic expWrite);
    wb_entry_t e;
    checkOutput("rf_write", rf_write, expWrite);
    if (rf_write) begin
      if (sbq.size() == 0) begin
        checkOutput("rf_write_unexpected", rf_write, 0);
      end else begin
        e = sbq.pop_front();
        checkOutput("rf_wr", rf_wr, e.addr);
        checkOutput("rf_wd", rf_wd, e.data);
      end
    end
    checkOutput("count", count, mCount);
    checkOutput("in_ready", in_ready, (mCount <= DEPTH - 2));
    checkOutput("err_ovf", err_ovf, mOvf);
`ifdef WBQ_FWD_EN
    begin
      logic [DW:0] f;
      f = fwdModel(tbFwdAddr);
      checkOutput("fwd_hit", fwd_hit, f[DW]);
      if (f[DW]) checkOutput("fwd_data", fwd_data, f[DW-1:0]);
    end
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, check after the edge.
  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic [AW-1:0] fa);
    logic ready, pop, acc0, acc1;
    in0_valid = v0; in0_addr = a0; in0_data = d0;
    in1_valid = v1; in1_addr = a1; in1_data = d1;
    tbFwdAddr = fa;
    ready = (mCount <= DEPTH - 2);
    pop   = (mCount != 0);
    mLastValid = pop;
    if (pop) mLast = sbq[0];
    if (!ready && (v0 || v1)) mOvf = 1'b1;
    acc0 = ready && v0 && (a0 != '0);
    acc1 = ready && v1 && (a1 != '0);
    if (acc0) sbq.push_back('{addr: a0, data: d0});
    if (acc1) sbq.push_back('{addr: a1, data: d1});
    mCount = mCount + int'(acc0) + int'(acc1) - int'(pop);
    @(posedge clk);
    @(negedge clk);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    checkState(pop);
  endtask

  task automatic idle(input int n, input logic [AW-1:0] fa);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, '0, fa);
  endtask

  // One-cycle reset, then check every reset value the write port and status expose.
  task automatic doReset();
    reset = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sbq.delete();
    mCount = 0;
    mOvf = 1'b0;
    mLastValid = 1'b0;
    checkOutput("rst_rf_write", rf_write, 0);
    checkOutput("rst_rf_wr", rf_wr, 0);
    checkOutput("rst_rf_wd", rf_wd, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_err_ovf", err_ovf, 0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
    in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
    tbFwdAddr = '0;
    mCount = 0; mOvf = 1'b0; mLastValid = 1'b0; mLast = '0;
    @(negedge clk);
    doReset();

    $display("[TB] single push latency");
    applyStimulus(1, 5'd3, 32'h1111_0001, 0, '0, '0, 5'd3);
    idle(2, 5'd3);

    $display("[TB] dual push to the same register");
    applyStimulus(1, 5'd5, 32'hA, 1, 5'd5, 32'hB, 5'd5);
    idle(3, 5'd5);

    $display("[TB] register zero filter");
    applyStimulus(1, 5'd0, 32'hDEAD, 1, 5'd7, 32'h7, 5'd0);
    idle(2, 5'd7);

    $display("[TB] fill to backpressure and overflow");
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom,
                    5'($urandom_range(0, 31)));
    applyStimulus(1, 5'd9, 32'h9999_9999, 1, 5'd10, 32'hAAAA_AAAA, 5'd9);

    $display("[TB] random legal traffic across pointer wrap");
    for (int i = 0; i < 40; i++) begin
      if (mCount <= DEPTH - 2)
        applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                      $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                      5'($urandom_range(0, 31)));
      else
        idle(1, 5'($urandom_range(0, 31)));
    end
    idle(10, 5'd1);

    $display("[TB] simultaneous push and pop at DEPTH-2");
    doReset();
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 5'(i + 1), 32'(i * 16), 1, 5'(i + 11), 32'(i * 16 + 1), 5'(i + 1));
    applyStimulus(1, 5'd20, 32'h2020_2020, 0, '0, '0, 5'd20);

    $display("[TB] reset mid-drain");
    doReset();
    idle(3, 5'd20);

    checkOutput("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue feeding the single write port of the 32×32 register file in the dual-issue pipeline. Accepts up to two retiring results per cycle (slot 0 older than slot 1), buffers them in program order, and drains exactly one per cycle onto the register-file write port. Writes to register 0 are discarded at entry. An optional forwarding port lets decode see values still pending in the queue.

## Interface
Parameters:
- DEPTH, 8: queue entries; power of two, ≥4.
- DW, 32: data width.
- AW, 5: register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- in0_valid  in  1  slot-0 result valid (older).
- in0_addr  in  AW  slot-0 destination register.
- in0_data  in  DW  slot-0 result.
- in1_valid  in  1  slot-1 result valid (younger).
- in1_addr  in  AW  slot-1 destination register.
- in1_data  in  DW  slot-1 result.
- in_ready  out  1  ≥2 free entries; combinational from registered count.
- rf_write  out  1  registered write enable to register file.
- rf_wr  out  AW  registered write address.
- rf_wd  out  DW  registered write data.
- count  out  $clog2(DEPTH)+1  occupied entries.
- err_ovf  out  1  sticky: valid presented while in_ready=0.
- fwd_addr  in  AW  lookup address (WBQ_FWD_EN only).
- fwd_hit  out  1  pending write to fwd_addr exists (WBQ_FWD_EN only).
- fwd_data  out  DW  youngest pending value for fwd_addr (WBQ_FWD_EN only).

## Operation
- Push: when in_ready=1, each slot with valid=1 and addr≠0 is enqueued; slot 0 first when both push. Both slots may target the same register; both are enqueued in order.
- Producers must only assert valid when in_ready=1. A valid presented while in_ready=0 is ignored (not enqueued) and sets err_ovf; err_ovf is cleared only by reset.
- Pop: each cycle with count≠0, the head entry is removed and loaded into rf_wr/rf_wd with rf_write=1. With count=0, rf_write=0; rf_wr and rf_wd hold their last values.
- Count update: count' = count + pushes − pop (pushes ∈ {0,1,2}, pop ∈ {0,1}). Push and pop in the same cycle are always legal.
- Pointers wrap modulo DEPTH. The write pointer advances by the number of pushes. Slot-1 data lands at wptr+1 when both slots push, otherwise at wptr.
- in_ready = (DEPTH − count) ≥ 2.
- Reset values: count=0, pointers=0, rf_write=0, rf_wr=0, rf_wd=0, err_ovf=0, in_ready=1, fwd_hit=0. Reset mid-operation discards all pending entries. No rf_write pulse occurs in the cycle after reset.

## Timing
- Latency: a result accepted at edge N into an empty queue produces rf_write=1 during the cycle after edge N+1. Input to write enable is 2 cycles.
- Throughput: 1 write per cycle sustained. A 2-wide burst drains at 1 per cycle.
- Outputs are stable for the full cycle so the register file can sample them on the falling edge.
- Drain order equals acceptance order; slot 0 precedes slot 1 within a cycle.
- Forwarding is combinational from fwd_addr and current state. No same-cycle input bypass.

## Configuration
- WBQ_FWD_EN defined:
  - fwd_addr, fwd_hit and fwd_data exist.
  - Lookup searches all valid queue entries plus the rf_* output register when rf_write=1.
  - Priority is youngest first: newest queue entry, then older entries, then the output register.
  - fwd_addr=0 always gives fwd_hit=0.
- WBQ_FWD_EN undefined: the three ports and the match logic are absent. Behaviour is otherwise identical.

## Structure
- Package wbq_pkg holds:
  - typedef wb_entry_t {addr[AW], data[DW]}
  - constant WBQ_REG_ZERO = 0
- Sub-module wbq_fwd_match: youngest-first priority match over entry array plus output register. Instantiated only under WBQ_FWD_EN.
- Storage, pointers, count and the output register live in wb_queue.

## Test plan
- Single push: reset, then in0 (addr 3, 0x1111_0001) at edge 1 → rf_write=1, rf_wr=3, rf_wd=0x1111_0001 during the cycle after edge 2; count returns to 0.
- Dual push same register: in0 (5, 0xA), in1 (5, 0xB) → two consecutive writes, 0xA then 0xB; fwd on addr 5 returns 0xB until the last write retires.
- Zero filter: in0 (0, 0xDEAD), in1 (7, 0x7) → only one write (addr 7); count peaks at 1.
- Fill/backpressure: DEPTH=8, dual push every cycle → in_ready drops when count reaches 7. A valid presented then sets err_ovf and count does not exceed 8. Drain order is intact across pointer wrap.
- Reset mid-drain: 6 pending entries, assert reset for one cycle → count=0 and rf_write=0 next cycle; no stale writes follow.
- Simultaneous push/pop at count=DEPTH−2: one push and one pop → count unchanged, in_ready stays 1.
